// File: rtl/tmr_divider.sv
// tmr_divider: three-lane sign-magnitude fixed-point restoring divider whose outputs are bitwise 2-of-3 voted.
// Define TMR_FAULT_INJECT_EN to add inj_en/inj_lane ports that invert one lane's quotient bit.
module tmr_divider #(
  parameter int WIDTH     = 16,
  parameter int INT_BITS  = 6,
  parameter int FRAC_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             invalid,
  output logic             ovf
`ifdef TMR_FAULT_INJECT_EN
  ,
  input  logic             inj_en,
  input  logic [1:0]       inj_lane
`endif
);
  localparam int M    = WIDTH - 1;
  localparam int ITER = M + FRAC_BITS;
  localparam int QW   = ITER + 1;
  localparam int CW   = $clog2(QW + 1);
  if (WIDTH != INT_BITS + FRAC_BITS) begin : g_bad_fmt
    $error("tmr_divider: WIDTH must equal INT_BITS+FRAC_BITS");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0][QW-1:0] quo_q, quo_d;
  logic [2:0][M-1:0] rem_q, rem_d, dvs_q, mag;
  logic [2:0][M:0] trial, diff;
  logic [2:0][WIDTH:0] lane;
  logic [2:0] sgn_q, ge, flip, sat;
  logic [WIDTH:0] vote;
  logic [WIDTH-1:0] result_q;
  logic invalid_q, ovf_q, accept, calc, last;
  assign accept = state_q == IDLE && in_valid;
  assign calc = state_q == CALC;
  assign last = calc && cnt_q == CW'(ITER);
`ifdef TMR_FAULT_INJECT_EN
  always_comb begin
    flip = '0;
    for (int l = 0; l < 3; l++) flip[l] = inj_en && inj_lane == 2'(l);
  end
`else
  assign flip = '0;
`endif
  // The dividend carries one leading zero bit, so a lane runs ITER+1 steps.
  always_comb begin
    state_d = accept ? CALC : last ? DONE : (state_q == DONE && out_ready) ? IDLE : state_q;
    for (int l = 0; l < 3; l++) begin
      trial[l] = {rem_q[l], quo_q[l][QW-1]};
      diff[l] = trial[l] - {1'b0, dvs_q[l]};
      ge[l] = trial[l] >= {1'b0, dvs_q[l]};
      quo_d[l] = accept ? {1'b0, a[M-1:0], {FRAC_BITS{1'b0}}} :
                 calc ? {quo_q[l][QW-2:0], ge[l] ^ flip[l]} : quo_q[l];
      rem_d[l] = accept ? '0 : calc ? (ge[l] ? diff[l][M-1:0] : trial[l][M-1:0]) : rem_q[l];
      sat[l] = dvs_q[l] == '0 || |quo_d[l][QW-1:M];
      mag[l] = sat[l] ? '1 : quo_d[l][M-1:0];
      lane[l] = {sat[l], sgn_q[l] & |mag[l], mag[l]};
    end
    vote = (lane[0] & lane[1]) | (lane[0] & lane[2]) | (lane[1] & lane[2]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      sgn_q <= '0;
      result_q <= '0;
      invalid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= calc ? cnt_q + 1'b1 : '0;
      quo_q <= quo_d;
      rem_q <= rem_d;
      if (accept) begin
        dvs_q <= {3{b[M-1:0]}};
        sgn_q <= {3{a[M] ^ b[M]}};
      end
      if (last) begin
        result_q <= vote[WIDTH-1:0];
        ovf_q <= vote[WIDTH];
        invalid_q <= lane[0] != lane[1] || lane[1] != lane[2];
      end
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign invalid = invalid_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_tmr_divider.sv
// tb_tmr_divider: directed and random division checks against an arithmetic reference model.
module tb_tmr_divider;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, in_ready, out_valid, invalid, ovf;
  logic [15:0] a, b, result;
  int errors = 0;
  int checks = 0;
`ifdef TMR_FAULT_INJECT_EN
  logic inj_en;
  logic [1:0] inj_lane;
`endif
  tmr_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .invalid(invalid), .ovf(ovf)
`ifdef TMR_FAULT_INJECT_EN
    , .inj_en(inj_en), .inj_lane(inj_lane)
`endif
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Q6.10 sign-magnitude quotient straight from the arithmetic definition: {ovf, result}.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
    longint q;
    logic o, s;
    logic [14:0] m;
    q = (y[14:0] == 0) ? 0 : (longint'(x[14:0]) * 1024) / longint'(y[14:0]);
    o = (y[14:0] == 0) || (q > 32767);
    m = o ? 15'h7FFF : q[14:0];
    s = (m != 0) && (x[15] ^ y[15]);
    return {o, s, m};
  endfunction

  task automatic run(input logic [15:0] ta, input logic [15:0] tb, input int hold);
    logic [16:0] e;
    logic ei;
    int n;
    e = model(ta, tb);
    ei = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
`ifdef TMR_FAULT_INJECT_EN
    ei = inj_lane != 2'd3;
    inj_en = 1'b1;
    @(negedge clk);
    inj_en = 1'b0;
    n = 1;
`endif
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 26);
    chk("result", result, e[15:0]);
    chk("ovf", ovf, e[16]);
    chk("invalid", invalid, ei);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, e[15:0]);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("result_kept", result, e[15:0]);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
`ifdef TMR_FAULT_INJECT_EN
    inj_en = 1'b0;
    inj_lane = 2'd3;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_invalid", invalid, 0);
    run(16'h0066, 16'h000A, 0);
    chk("t1_value", result, 16'h28CC);
    run(16'h0600, 16'h0400, 0);
    run(16'h0866, 16'h8600, 0);
    chk("t2_value", result, 16'h8599);
    run(16'h0400, 16'h0000, 0);
    run(16'h8400, 16'h8000, 0);
    chk("t3_value", result, 16'h7FFF);
    run(16'h7C00, 16'h0066, 0);
    run(16'h0000, 16'h8400, 0);
    run(16'h8000, 16'h0400, 1);
    run(16'h0066, 16'h000A, 10);
    run(16'h0400, 16'h0000, 0);
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h1234;
    b = 16'h0042;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_invalid", invalid, 0);
    run(16'h0866, 16'h8600, 0);
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(2) == 0) ? {1'($urandom_range(1)), 15'($urandom_range(40))} : 16'($urandom);
      run(ra, rb, $urandom_range(3));
    end
`ifdef TMR_FAULT_INJECT_EN
    inj_lane = 2'd1;
    run(16'h0066, 16'h000A, 0);
    chk("inj_value", result, 16'h28CC);
    inj_lane = 2'd3;
    run(16'h0066, 16'h000A, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
